// File: rtl/inst_commit.sv
// Commit/writeback stage: architectural GPR/CP0 writes, debug trace, precise exception
// commit with vector redirect, and a fixed-length squash of wrong-path instructions.
package inst_commit_pkg;
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wrdata;
  } regs_wreq_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wrdata;
  } cp0_wreq_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] extra;
    logic        tlb_refill;
  } exception_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [3:0]  regs_wbe;
  } debug_req_t;

  typedef struct packed {
    regs_wreq_t regs_wreq;
    cp0_wreq_t  cp0_wreq;
    exception_t exception;
    debug_req_t debug_req;
  } pipe_ex_t;
endpackage

module inst_commit #(
  parameter int          SQUASH_CYCLES  = 2,
  parameter logic [31:0] REFILL_OFFSET  = 32'h0000_0000,
  parameter logic [31:0] GENERAL_OFFSET = 32'h0000_0180
) (
  input  logic                      clk,
  input  logic                      rst,
  input  inst_commit_pkg::pipe_ex_t pipe_ex,
  input  logic [31:0]               cp0_ebase,
  input  logic                      cp0_exl,
  output logic                      regs_we,
  output logic [4:0]                regs_waddr,
  output logic [31:0]               regs_wrdata,
  output logic                      cp0_we,
  output logic [4:0]                cp0_waddr,
  output logic [2:0]                cp0_wsel,
  output logic [31:0]               cp0_wrdata,
  output logic                      exc_valid,
  output logic [4:0]                exc_code,
  output logic [31:0]               exc_epc,
  output logic [31:0]               exc_badvaddr,
  output logic                      exc_tlb_refill,
  output logic                      flush_o,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic                      busy_o,
  output logic [31:0]               debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [31:0]               debug_wb_rf_wdata
);

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       take_exc, commit_ok;

  function automatic logic [31:0] vector_pc(input logic [31:0] ebase, input logic refill,
                                            input logic exl);
    return ebase + ((refill && !exl) ? REFILL_OFFSET : GENERAL_OFFSET);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_exc  = 1'b0;
    commit_ok = 1'b0;
    case (state)
      IDLE: begin
        if (pipe_ex.exception.valid) begin
          take_exc  = 1'b1;
          state_nxt = SQUASH;
          cnt_nxt   = 4'(SQUASH_CYCLES);
        end else begin
          commit_ok = 1'b1;
        end
      end
      SQUASH: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == SQUASH);

  // Commit stage register: outputs are valid one cycle after pipe_ex is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_we           <= 1'b0;
      regs_waddr        <= '0;
      regs_wrdata       <= '0;
      cp0_we            <= 1'b0;
      cp0_waddr         <= '0;
      cp0_wsel          <= '0;
      cp0_wrdata        <= '0;
      exc_valid         <= 1'b0;
      exc_code          <= '0;
      exc_epc           <= '0;
      exc_badvaddr      <= '0;
      exc_tlb_refill    <= 1'b0;
      flush_o           <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      regs_we         <= commit_ok && pipe_ex.regs_wreq.we && (pipe_ex.regs_wreq.waddr != 5'd0);
      cp0_we          <= commit_ok && pipe_ex.cp0_wreq.we;
      debug_wb_rf_wen <= (commit_ok && pipe_ex.regs_wreq.waddr != 5'd0) ?
                         pipe_ex.debug_req.regs_wbe : 4'd0;
      exc_valid       <= take_exc;
      flush_o         <= take_exc;
      redirect_valid  <= take_exc;
      if (commit_ok) begin
        regs_waddr        <= pipe_ex.regs_wreq.waddr;
        regs_wrdata       <= pipe_ex.regs_wreq.wrdata;
        cp0_waddr         <= pipe_ex.cp0_wreq.waddr;
        cp0_wsel          <= pipe_ex.cp0_wreq.wsel;
        cp0_wrdata        <= pipe_ex.cp0_wreq.wrdata;
        debug_wb_pc       <= pipe_ex.debug_req.vaddr;
        debug_wb_rf_wnum  <= pipe_ex.regs_wreq.waddr;
        debug_wb_rf_wdata <= pipe_ex.regs_wreq.wrdata;
      end
      // Exception record and vector persist until the next exception commit
      if (take_exc) begin
        exc_code       <= pipe_ex.exception.code;
        exc_epc        <= pipe_ex.debug_req.vaddr;
        exc_badvaddr   <= pipe_ex.exception.extra;
        exc_tlb_refill <= pipe_ex.exception.tlb_refill;
        redirect_pc    <= vector_pc(cp0_ebase, pipe_ex.exception.tlb_refill, cp0_exl);
      end
    end
  end

endmodule

// File: tb/tb_inst_commit.sv
// Self-checking bench for inst_commit: directed steps with randomized payloads
// compared against a rule-level reference model.
module tb_inst_commit;
  import inst_commit_pkg::*;

  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  pipe_ex_t    pipe_ex = '0;
  logic [31:0] cp0_ebase = '0;
  logic        cp0_exl = 1'b0;
  logic        regs_we, cp0_we, exc_valid, exc_tlb_refill, flush_o, redirect_valid, busy_o;
  logic [4:0]  regs_waddr, cp0_waddr, exc_code, debug_wb_rf_wnum;
  logic [2:0]  cp0_wsel;
  logic [3:0]  debug_wb_rf_wen;
  logic [31:0] regs_wrdata, cp0_wrdata, exc_epc, exc_badvaddr, redirect_pc;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_squash = 0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0, m_bad = '0, m_rpc = '0;
  logic        m_refill = 1'b0;
  int          exc_pulses = 0;

  inst_commit #(.SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .rst(rst), .pipe_ex(pipe_ex), .cp0_ebase(cp0_ebase), .cp0_exl(cp0_exl),
    .regs_we(regs_we), .regs_waddr(regs_waddr), .regs_wrdata(regs_wrdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wrdata(cp0_wrdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_tlb_refill(exc_tlb_refill), .flush_o(flush_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy_o(busy_o),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pipe_ex_t mk_alu(input logic [4:0] rd, input logic [31:0] data,
                                      input logic [31:0] pc);
    pipe_ex_t p = '0;
    p.regs_wreq.we = 1'b1;
    p.regs_wreq.waddr = rd;
    p.regs_wreq.wrdata = data;
    p.debug_req.vaddr = pc;
    p.debug_req.regs_wbe = 4'hF;
    return p;
  endfunction

  function automatic pipe_ex_t mk_exc(input logic [4:0] code, input logic [31:0] extra,
                                      input logic refill, input logic [31:0] pc);
    pipe_ex_t p = '0;
    p.regs_wreq.we = 1'b1;
    p.regs_wreq.waddr = 5'd7;
    p.regs_wreq.wrdata = 32'hDEAD_BEEF;
    p.cp0_wreq.we = 1'b1;
    p.exception.valid = 1'b1;
    p.exception.code = code;
    p.exception.extra = extra;
    p.exception.tlb_refill = refill;
    p.debug_req.vaddr = pc;
    p.debug_req.regs_wbe = 4'hF;
    return p;
  endfunction

  function automatic pipe_ex_t rand_instr();
    pipe_ex_t p = '0;
    p.regs_wreq.we = 1'($urandom_range(0, 1));
    p.regs_wreq.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    p.regs_wreq.wrdata = $urandom;
    p.cp0_wreq.we = 1'($urandom_range(0, 1));
    p.cp0_wreq.waddr = 5'($urandom);
    p.cp0_wreq.wsel = 3'($urandom);
    p.cp0_wreq.wrdata = $urandom;
    p.debug_req.vaddr = $urandom;
    p.debug_req.regs_wbe = 4'($urandom);
    return p;
  endfunction

  // Apply one instruction, advance one clock, compare against the model's rules.
  task automatic step(input pipe_ex_t p, input logic [31:0] ebase, input logic exl);
    logic normal, exc;
    pipe_ex = p;
    cp0_ebase = ebase;
    cp0_exl = exl;
    normal = (m_squash == 0) && !p.exception.valid;
    exc = (m_squash == 0) && p.exception.valid;
    if (m_squash > 0) m_squash--;
    else if (exc) begin
      m_squash = SQ;
      m_code = p.exception.code;
      m_epc = p.debug_req.vaddr;
      m_bad = p.exception.extra;
      m_refill = p.exception.tlb_refill;
      m_rpc = ebase + ((p.exception.tlb_refill && !exl) ? 32'h0 : 32'h180);
    end
    @(posedge clk);
    #1;
    chk("regs_we", 32'(regs_we), 32'(normal && p.regs_wreq.we && p.regs_wreq.waddr != 0));
    chk("cp0_we", 32'(cp0_we), 32'(normal && p.cp0_wreq.we));
    chk("rf_wen", 32'(debug_wb_rf_wen),
        (normal && p.regs_wreq.waddr != 0) ? 32'(p.debug_req.regs_wbe) : 32'd0);
    chk("exc_valid", 32'(exc_valid), 32'(exc));
    chk("flush_o", 32'(flush_o), 32'(exc));
    chk("redirect_valid", 32'(redirect_valid), 32'(exc));
    chk("busy_o", 32'(busy_o), 32'(m_squash > 0));
    chk("exc_code", 32'(exc_code), 32'(m_code));
    chk("exc_epc", exc_epc, m_epc);
    chk("exc_badvaddr", exc_badvaddr, m_bad);
    chk("exc_tlb_refill", 32'(exc_tlb_refill), 32'(m_refill));
    chk("redirect_pc", redirect_pc, m_rpc);
    if (normal) begin
      chk("regs_waddr", 32'(regs_waddr), 32'(p.regs_wreq.waddr));
      chk("regs_wrdata", regs_wrdata, p.regs_wreq.wrdata);
      chk("cp0_waddr", 32'(cp0_waddr), 32'(p.cp0_wreq.waddr));
      chk("cp0_wsel", 32'(cp0_wsel), 32'(p.cp0_wreq.wsel));
      chk("cp0_wrdata", cp0_wrdata, p.cp0_wreq.wrdata);
      chk("wb_pc", debug_wb_pc, p.debug_req.vaddr);
      chk("wb_wnum", 32'(debug_wb_rf_wnum), 32'(p.regs_wreq.waddr));
      chk("wb_wdata", debug_wb_rf_wdata, p.regs_wreq.wrdata);
    end
    if (exc_valid) exc_pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_squash = 0;
    m_code = '0; m_epc = '0; m_bad = '0; m_rpc = '0; m_refill = 1'b0;
    chk("rst_ctrl", {25'd0, regs_we, cp0_we, exc_valid, flush_o, redirect_valid, busy_o,
                     exc_tlb_refill}, 32'd0);
    chk("rst_addr", {14'd0, regs_waddr, cp0_waddr, cp0_wsel, exc_code}, 32'd0);
    chk("rst_data", regs_wrdata | cp0_wrdata | exc_epc | exc_badvaddr | redirect_pc, 32'd0);
    chk("rst_trace", debug_wb_pc | debug_wb_rf_wdata | 32'(debug_wb_rf_wen)
                     | 32'(debug_wb_rf_wnum), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    pipe_ex_t p;
    int pulses_before;
    #2;
    // Reset with garbage on the input
    pipe_ex = rand_instr();
    @(posedge clk);
    do_reset();

    // Normal commit, $0 write, bubble
    step(mk_alu(5'd5, 32'h1234, 32'hBFC0_0000), 32'h8000_0000, 1'b0);
    chk("addu_wen_F", 32'(debug_wb_rf_wen), 32'hF);
    step(mk_alu(5'd0, 32'h5555, 32'hBFC0_0004), 32'h8000_0000, 1'b0);
    chk("r0_pc", debug_wb_pc, 32'hBFC0_0004);
    step('0, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 20; i++) step(rand_instr(), $urandom, 1'($urandom));

    // SYSCALL, then two squashed ADDUs (second slot carries an exception), then a commit
    step(mk_exc(5'd8, 32'h0, 1'b0, 32'hBFC0_0100), 32'h8000_0000, 1'b0);
    chk("sys_rpc", redirect_pc, 32'h8000_0180);
    chk("sys_epc", exc_epc, 32'hBFC0_0100);
    pulses_before = exc_pulses;
    step(mk_alu(5'd3, 32'h11, 32'hBFC0_0104), 32'h8000_0000, 1'b0);
    step(mk_exc(5'd10, 32'h77, 1'b0, 32'hBFC0_0108), 32'h8000_0000, 1'b0);
    chk("squash_no_exc", 32'(exc_pulses), 32'(pulses_before));
    step(mk_alu(5'd4, 32'h22, 32'hBFC0_010C), 32'h8000_0000, 1'b0);
    chk("post_squash_we", 32'(regs_we), 32'd1);

    // TLB refill vectors with EXL clear and set
    step(mk_exc(5'd2, 32'h0040_1000, 1'b1, 32'h0040_0020), 32'h8000_0000, 1'b0);
    chk("refill_rpc", redirect_pc, 32'h8000_0000);
    step('0, 32'h0, 1'b0);
    step('0, 32'h0, 1'b0);
    step(mk_exc(5'd2, 32'h0040_2000, 1'b1, 32'h0040_0024), 32'h8000_0000, 1'b1);
    chk("refill_exl_rpc", redirect_pc, 32'h8000_0180);
    chk("refill_bad", exc_badvaddr, 32'h0040_2000);
    step('0, 32'h0, 1'b0);
    step('0, 32'h0, 1'b0);
    step(mk_exc(5'd4, 32'h1, 1'b0, 32'h1000), 32'hFFFF_FF00, 1'b0);
    chk("wrap_rpc", redirect_pc, 32'h0000_0080);
    step('0, 32'h0, 1'b0);
    step('0, 32'h0, 1'b0);

    // Random mix of commits, bubbles and exceptions
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0, 1: p = mk_exc(5'($urandom), $urandom, 1'($urandom), $urandom);
        2:    p = '0;
        default: p = rand_instr();
      endcase
      step(p, $urandom, 1'($urandom));
    end
    while (m_squash > 0) step('0, 32'h0, 1'b0);

    // Reset one cycle into squash, then a clean commit
    step(mk_exc(5'd8, 32'h0, 1'b0, 32'hBFC0_0200), 32'h8000_0000, 1'b0);
    step(mk_alu(5'd6, 32'h66, 32'hBFC0_0204), 32'h8000_0000, 1'b0);
    do_reset();
    step(mk_alu(5'd5, 32'h1234, 32'hBFC0_0300), 32'h8000_0000, 1'b0);
    chk("after_rst_we", 32'(regs_we), 32'd1);
    chk("after_rst_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
